// File: rtl/note_pkg.sv
// Shared note-code field positions, stabilizer states and event bundle.
// Imported by the frequency-to-note stage and the note stabilizer.
package note_pkg;

    localparam int NOTE_MSB = 7;
    localparam int ACC_MSB  = 4;
    localparam int OCT_MSB  = 2;

    typedef enum logic [1:0] {
        SILENT,
        QUALIFY,
        HELD
    } stab_state_t;

    typedef struct packed {
        logic       on;
        logic [7:0] note;
    } note_event_t;

endpackage

// File: rtl/note_event_fifo.sv
// Two-entry event queue: up to two pushes and one pop per cycle.
// Ports: push0/ev0 and push1/ev1 (ev0 older), ready in, valid/head out, drop pulse out.
module note_event_fifo
    import note_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push0,
    input  note_event_t ev0,
    input  logic        push1,
    input  note_event_t ev1,
    input  logic        ready,
    output logic        valid,
    output note_event_t head,
    output logic        drop
);

    note_event_t slot_q [2];
    note_event_t slot_d [2];
    logic [1:0]  count_q;
    logic [1:0]  count_d;
    logic        pop;

    assign valid = (count_q != 2'd0);
    assign head  = slot_q[0];
    assign pop   = valid && ready;

    // Pop shifts the queue first so the freed slot is usable this cycle.
    always_comb begin
        slot_d  = slot_q;
        count_d = count_q;
        drop    = 1'b0;
        if (pop) begin
            slot_d[0] = slot_q[1];
            count_d   = count_q - 2'd1;
        end
        if (push0) begin
            if (count_d < 2'd2) begin
                slot_d[count_d[0]] = ev0;
                count_d            = count_d + 2'd1;
            end else begin
                drop = 1'b1;
            end
        end
        if (push1) begin
            if (count_d < 2'd2) begin
                slot_d[count_d[0]] = ev1;
                count_d            = count_d + 2'd1;
            end else begin
                drop = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q[0] <= '0;
            slot_q[1] <= '0;
            count_q   <= 2'd0;
        end else begin
            slot_q[0] <= slot_d[0];
            slot_q[1] <= slot_d[1];
            count_q   <= count_d;
        end
    end

endmodule

// File: rtl/note_stabilizer.sv
// Debounces per-sample note codes into note-on/note-off events.
// Ports: sample strobe/code/silent in; event valid/ready/on/note; held note, active, sticky overflow.
module note_stabilizer
    import note_pkg::*;
#(
    parameter int STABLE_COUNT = 8,
    parameter int CNT_W        = $clog2(STABLE_COUNT + 1)
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       note_valid_in,
    input  logic [7:0] note_code_in,
    input  logic       silent_in,
    output logic       event_valid_out,
    input  logic       event_ready_in,
    output logic       event_on_out,
    output logic [7:0] event_note_out,
    output logic [7:0] current_note_out,
    output logic       note_active_out,
    output logic       overflow_out
);

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STABLE_COUNT);
    localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

    stab_state_t state_q, state_d;
    logic [7:0]  cand_q, cand_d;
    logic [7:0]  held_q, held_d;
    logic [CNT_W-1:0] match_q, match_d, match_inc;
    logic [CNT_W-1:0] sil_q, sil_d, sil_inc;
    logic        ovf_q;
    logic        push0, push1, drop;
    note_event_t ev0, ev1, head;

    assign match_inc = match_q + ONE;
    assign sil_inc   = sil_q + ONE;

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        held_d  = held_q;
        match_d = match_q;
        sil_d   = sil_q;
        push0   = 1'b0;
        push1   = 1'b0;
        ev0     = '0;
        ev1     = '0;
        if (note_valid_in) begin
            unique case (state_q)
                SILENT: begin
                    if (!silent_in) begin
                        cand_d  = note_code_in;
                        match_d = ONE;
                        state_d = QUALIFY;
                    end
                end
                QUALIFY: begin
                    if (silent_in) begin
                        state_d = SILENT;
                        match_d = '0;
                        sil_d   = '0;
                    end else if (note_code_in == cand_q) begin
                        if (match_inc == LIMIT) begin
                            held_d  = cand_q;
                            push0   = 1'b1;
                            ev0     = '{on: 1'b1, note: cand_q};
                            state_d = HELD;
                            match_d = '0;
                            sil_d   = '0;
                        end else begin
                            match_d = match_inc;
                        end
                    end else begin
                        cand_d  = note_code_in;
                        match_d = ONE;
                    end
                end
                HELD: begin
                    if (silent_in) begin
                        match_d = '0;
                        if (sil_inc == LIMIT) begin
                            push0   = 1'b1;
                            ev0     = '{on: 1'b0, note: held_q};
                            held_d  = '0;
                            sil_d   = '0;
                            state_d = SILENT;
                        end else begin
                            sil_d = sil_inc;
                        end
                    end else if (note_code_in == held_q) begin
                        match_d = '0;
                        sil_d   = '0;
                    end else begin
                        sil_d = '0;
                        // A stale cand with match_q==0 restarts the count at 1.
                        if (note_code_in == cand_q) begin
                            if (match_inc == LIMIT) begin
                                push0   = 1'b1;
                                ev0     = '{on: 1'b0, note: held_q};
                                push1   = 1'b1;
                                ev1     = '{on: 1'b1, note: cand_q};
                                held_d  = cand_q;
                                match_d = '0;
                            end else begin
                                match_d = match_inc;
                            end
                        end else begin
                            cand_d  = note_code_in;
                            match_d = ONE;
                        end
                    end
                end
                default: state_d = SILENT;
            endcase
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= SILENT;
            cand_q  <= '0;
            held_q  <= '0;
            match_q <= '0;
            sil_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            held_q  <= held_d;
            match_q <= match_d;
            sil_q   <= sil_d;
            ovf_q   <= ovf_q | drop;
        end
    end

    note_event_fifo u_fifo (
        .clk   (clk_in),
        .rst_n (rst_n_in),
        .push0 (push0),
        .ev0   (ev0),
        .push1 (push1),
        .ev1   (ev1),
        .ready (event_ready_in),
        .valid (event_valid_out),
        .head  (head),
        .drop  (drop)
    );

    assign event_on_out     = head.on;
    assign event_note_out   = head.note;
    assign current_note_out = held_q;
    assign note_active_out  = (state_q == HELD);
    assign overflow_out     = ovf_q;

endmodule

// File: tb/tb_note_stabilizer.sv
// Directed bench for note_stabilizer (STABLE_COUNT=8).
// Records handshake beats and checks them against hand-computed events.
module tb_note_stabilizer;

    logic       clk_in = 1'b0;
    logic       rst_n_in = 1'b0;
    logic       note_valid_in = 1'b0;
    logic [7:0] note_code_in = '0;
    logic       silent_in = 1'b0;
    logic       event_valid_out;
    logic       event_ready_in = 1'b1;
    logic       event_on_out;
    logic [7:0] event_note_out;
    logic [7:0] current_note_out;
    logic       note_active_out;
    logic       overflow_out;

    int n_vec = 0;
    int n_err = 0;
    int base;
    logic [8:0] beats [$];

    always #5 clk_in = ~clk_in;

    note_stabilizer #(.STABLE_COUNT(8)) dut (
        .clk_in           (clk_in),
        .rst_n_in         (rst_n_in),
        .note_valid_in    (note_valid_in),
        .note_code_in     (note_code_in),
        .silent_in        (silent_in),
        .event_valid_out  (event_valid_out),
        .event_ready_in   (event_ready_in),
        .event_on_out     (event_on_out),
        .event_note_out   (event_note_out),
        .current_note_out (current_note_out),
        .note_active_out  (note_active_out),
        .overflow_out     (overflow_out)
    );

    // Beats complete on the edge; values read here are pre-edge.
    always @(posedge clk_in) begin
        if (rst_n_in && event_valid_out && event_ready_in)
            beats.push_back({event_on_out, event_note_out});
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic strobe(input logic [7:0] code, input logic sil);
        @(negedge clk_in);
        note_valid_in = 1'b1;
        note_code_in  = code;
        silent_in     = sil;
        @(negedge clk_in);
        note_valid_in = 1'b0;
    endtask

    task automatic strobes(input int n, input logic [7:0] code, input logic sil);
        for (int i = 0; i < n; i++) strobe(code, sil);
    endtask

    task automatic beat_at(input string tag, input int idx, input logic [8:0] exp);
        if (idx < beats.size())
            check(tag, 32'(beats[idx]), 32'(exp));
        else
            check({tag, "_missing"}, 32'(beats.size()), 32'(idx + 1));
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_valid"}, 32'(event_valid_out), 0);
        check({tag, "_on"}, 32'(event_on_out), 0);
        check({tag, "_enote"}, 32'(event_note_out), 0);
        check({tag, "_cur"}, 32'(current_note_out), 0);
        check({tag, "_act"}, 32'(note_active_out), 0);
        check({tag, "_ovf"}, 32'(overflow_out), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk_in);
        check_zero_outputs("reset");
        rst_n_in = 1'b1;

        // Accept: 7 samples give nothing, the 8th gives ON(44).
        strobes(7, 8'h44, 1'b0);
        check("acc7_beats", 32'(beats.size()), 0);
        check("acc7_valid", 32'(event_valid_out), 0);
        check("acc7_act", 32'(note_active_out), 0);
        strobe(8'h44, 1'b0);
        check("acc8_valid", 32'(event_valid_out), 1);
        check("acc8_on", 32'(event_on_out), 1);
        check("acc8_note", 32'(event_note_out), 32'h44);
        check("acc8_cur", 32'(current_note_out), 32'h44);
        check("acc8_act", 32'(note_active_out), 1);
        @(negedge clk_in);
        check("acc_beats", 32'(beats.size()), 1);
        beat_at("acc_beat0", 0, {1'b1, 8'h44});
        check("acc_drained", 32'(event_valid_out), 0);

        // Release: silence run broken by the held note restarts.
        strobes(7, 8'h00, 1'b1);
        strobe(8'h44, 1'b0);
        strobes(7, 8'h00, 1'b1);
        check("rel_early_beats", 32'(beats.size()), 1);
        check("rel_early_act", 32'(note_active_out), 1);
        strobe(8'h00, 1'b1);
        check("rel_cur", 32'(current_note_out), 0);
        check("rel_act", 32'(note_active_out), 0);
        @(negedge clk_in);
        check("rel_beats", 32'(beats.size()), 2);
        beat_at("rel_beat", 1, {1'b0, 8'h44});

        // Glitch reject from silence.
        strobes(5, 8'h44, 1'b0);
        strobe(8'h64, 1'b0);
        strobes(7, 8'h44, 1'b0);
        check("gl_beats", 32'(beats.size()), 2);
        check("gl_act", 32'(note_active_out), 0);
        strobe(8'h44, 1'b0);
        check("gl_act_on", 32'(note_active_out), 1);
        @(negedge clk_in);
        beat_at("gl_beat", 2, {1'b1, 8'h44});

        // Note change: OFF(44) then ON(64) on back-to-back beats.
        strobes(7, 8'h64, 1'b0);
        check("chg7_cur", 32'(current_note_out), 32'h44);
        strobe(8'h64, 1'b0);
        check("chg_cur", 32'(current_note_out), 32'h64);
        check("chg_head", 32'({event_on_out, event_note_out}), 32'h044);
        repeat (2) @(negedge clk_in);
        check("chg_beats", 32'(beats.size()), 5);
        beat_at("chg_off", 3, {1'b0, 8'h44});
        beat_at("chg_on", 4, {1'b1, 8'h64});
        check("chg_ovf", 32'(overflow_out), 0);

        // Overflow under backpressure.
        rst_n_in = 1'b0;
        event_ready_in = 1'b0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        base = beats.size();
        strobes(8, 8'h44, 1'b0);
        strobes(8, 8'h64, 1'b0);
        check("ovf_flag", 32'(overflow_out), 1);
        check("ovf_cur", 32'(current_note_out), 32'h64);
        check("ovf_head", 32'({event_valid_out, event_on_out, event_note_out}), 32'h344);
        repeat (3) @(negedge clk_in);
        check("ovf_head_stable", 32'({event_valid_out, event_on_out, event_note_out}), 32'h344);
        event_ready_in = 1'b1;
        repeat (3) @(negedge clk_in);
        check("ovf_beats", 32'(beats.size() - base), 2);
        beat_at("ovf_b0", base, {1'b1, 8'h44});
        beat_at("ovf_b1", base + 1, {1'b0, 8'h44});
        check("ovf_empty", 32'(event_valid_out), 0);
        check("ovf_sticky", 32'(overflow_out), 1);

        // Async reset with an event queued and a candidate in progress.
        event_ready_in = 1'b0;
        strobes(8, 8'h00, 1'b1);
        strobes(3, 8'h21, 1'b0);
        check("ar_queued", 32'(event_valid_out), 1);
        base = beats.size();
        #3 rst_n_in = 1'b0;
        #1 check_zero_outputs("ar");
        @(negedge clk_in);
        rst_n_in = 1'b1;
        event_ready_in = 1'b1;
        strobes(5, 8'h21, 1'b0);
        repeat (3) @(negedge clk_in);
        check("ar_no_events", 32'(beats.size() - base), 0);
        check("ar_act", 32'(note_active_out), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
